// File: rtl/serial_addsub_if.sv
// Handshake and result bundle for the digit-serial adder/subtractor.
// The controller drives the master side; the arithmetic unit uses the slave side.
interface serial_addsub_if #(
    parameter int N = 8
);
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry, overflow, zero, negative
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry, overflow, zero, negative
    );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, N/DIGIT steps,
// start/done handshake with optional signed saturation and registered status flags.
module serial_addsub #(
    parameter int N        = 8,
    parameter int DIGIT    = 1,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_addsub_if.slave bus
);
    localparam int STEPS = N / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_reg;
    logic [N-1:0]   opa_reg;
    logic [N-1:0]   opb_reg;
    logic           carry_reg;
    logic [CW-1:0]  cnt_reg;
    logic           a_sign_reg;
    logic           busy_reg;
    logic           done_reg;
    logic [N-1:0]   result_reg;
    logic           carry_out_reg;
    logic           overflow_reg;
    logic           zero_reg;
    logic           negative_reg;

    logic [DIGIT:0] digit_sum;
    logic           msb_cin;
    logic           ovf_next;
    logic [N-1:0]   sum_next;
    logic [N-1:0]   sat_value;
    logic [N-1:0]   result_next;
    logic           last_step;
    logic           accept;

    assign digit_sum = {1'b0, opa_reg[DIGIT-1:0]} + {1'b0, opb_reg[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_reg};

    // Carry into the digit MSB is recovered from its sum bit: s = a ^ b ^ cin.
    assign msb_cin  = digit_sum[DIGIT-1] ^ opa_reg[DIGIT-1] ^ opb_reg[DIGIT-1];
    assign ovf_next = digit_sum[DIGIT] ^ msb_cin;

    // Accumulator only needs the STEPS-1 earlier digits; the current digit lands on top.
    generate
        if (DIGIT == N) begin : g_single
            assign sum_next = digit_sum[DIGIT-1:0];
        end else begin : g_acc
            logic [N-DIGIT-1:0] acc_reg;
            logic [N-1:0]       acc_full;

            assign acc_full = {digit_sum[DIGIT-1:0], acc_reg};
            assign sum_next = acc_full;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (state_reg == RUN) begin
                    acc_reg <= acc_full[N-1:DIGIT];
                end
            end
        end
    endgenerate

    assign sat_value   = {a_sign_reg, {(N-1){~a_sign_reg}}};
    assign result_next = (SATURATE != 0 && ovf_next) ? sat_value : sum_next;
    assign last_step   = (cnt_reg == CW'(STEPS - 1));
    assign accept      = bus.start && (state_reg == IDLE || state_reg == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            opa_reg       <= '0;
            opb_reg       <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            a_sign_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            negative_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        opa_reg    <= bus.a;
                        opb_reg    <= bus.sub ? ~bus.b : bus.b;
                        carry_reg  <= bus.sub;
                        cnt_reg    <= '0;
                        a_sign_reg <= bus.a[N-1];
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end else begin
                        state_reg  <= IDLE;
                    end
                end
                RUN: begin
                    opa_reg   <= opa_reg >> DIGIT;
                    opb_reg   <= opb_reg >> DIGIT;
                    carry_reg <= digit_sum[DIGIT];
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_step) begin
                        result_reg    <= result_next;
                        carry_out_reg <= digit_sum[DIGIT];
                        overflow_reg  <= ovf_next;
                        zero_reg      <= (result_next == '0);
                        negative_reg  <= result_next[N-1];
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.result   = result_reg;
    assign bus.carry    = carry_out_reg;
    assign bus.overflow = overflow_reg;
    assign bus.zero     = zero_reg;
    assign bus.negative = negative_reg;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: four serial_addsub variants share stimulus; expected responses are
// queued at issue time and popped by a monitor whenever a unit pulses done.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    logic       start_drv = 1'b0;
    logic       sub_drv = 1'b0;
    logic [7:0] a_drv = 8'h00;
    logic [7:0] b_drv = 8'h00;
    logic [3:0] en_drv = 4'h0;

    logic [3:0] done_w, busy_w, carry_w, ovf_w, zero_w, neg_w;
    logic [7:0] res_w [4];

    // unit 0: DIGIT=1 wrap, 1: DIGIT=1 saturate, 2: DIGIT=4 wrap, 3: DIGIT=8 wrap
    int steps [4] = '{8, 8, 2, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    serial_addsub_if #(.N(8)) bus [4] ();

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wire
            assign bus[gi].start = start_drv & en_drv[gi];
            assign bus[gi].sub   = sub_drv;
            assign bus[gi].a     = a_drv;
            assign bus[gi].b     = b_drv;
            assign done_w[gi]    = bus[gi].done;
            assign busy_w[gi]    = bus[gi].busy;
            assign carry_w[gi]   = bus[gi].carry;
            assign ovf_w[gi]     = bus[gi].overflow;
            assign zero_w[gi]    = bus[gi].zero;
            assign neg_w[gi]     = bus[gi].negative;
            assign res_w[gi]     = bus[gi].result;
        end
    endgenerate

    serial_addsub #(.N(8), .DIGIT(1), .SATURATE(0)) u_d1  (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
    serial_addsub #(.N(8), .DIGIT(1), .SATURATE(1)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
    serial_addsub #(.N(8), .DIGIT(4), .SATURATE(0)) u_d4  (.clk(clk), .rst_n(rst_n), .bus(bus[2]));
    serial_addsub #(.N(8), .DIGIT(8), .SATURATE(0)) u_d8  (.clk(clk), .rst_n(rst_n), .bus(bus[3]));

    typedef struct packed {
        logic [7:0]  result;
        logic        carry;
        logic        overflow;
        logic        zero;
        logic        negative;
        logic [31:0] cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a, b;
        logic       sub;
        logic [7:0] r_wrap;
        logic       c, o, z_wrap, n_wrap;
        logic [7:0] r_sat;
        logic       z_sat, n_sat;
    } vec_t;

    vec_t vecs [9];
    exp_t q0[$], q1[$], q2[$], q3[$];

    task automatic set_vec(input int i, input logic [7:0] a, b, input logic sub,
                           input logic [7:0] rw, input logic c, o, zw, nw,
                           input logic [7:0] rs, input logic zs, ns);
        vecs[i].a = a; vecs[i].b = b; vecs[i].sub = sub;
        vecs[i].r_wrap = rw; vecs[i].c = c; vecs[i].o = o;
        vecs[i].z_wrap = zw; vecs[i].n_wrap = nw;
        vecs[i].r_sat = rs; vecs[i].z_sat = zs; vecs[i].n_sat = ns;
    endtask

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic pop_exp(input int k, output exp_t e);
        case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    task automatic clear_queues();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s unit%0d got=0x%0h expected=0x%0h", name, k, got, exp);
        end
    endtask

    // Called at a negedge; drives one start pulse and queues the expected responses.
    task automatic issue(input logic [3:0] mask, input int idx);
        exp_t e;
        a_drv = vecs[idx].a; b_drv = vecs[idx].b; sub_drv = vecs[idx].sub;
        en_drv = mask; start_drv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                e.result   = (k == 1) ? vecs[idx].r_sat : vecs[idx].r_wrap;
                e.carry    = vecs[idx].c;
                e.overflow = vecs[idx].o;
                e.zero     = (k == 1) ? vecs[idx].z_sat : vecs[idx].z_wrap;
                e.negative = (k == 1) ? vecs[idx].n_sat : vecs[idx].n_wrap;
                e.cyc      = 32'(cyc_cnt + 1 + steps[k]);
                push_exp(k, e);
            end
        end
        @(negedge clk);
        start_drv = 1'b0;
    endtask

    task automatic wait_drain();
        int pending;
        pending = 1;
        for (int i = 0; i < 40 && pending != 0; i++) begin
            pending = qsize(0) + qsize(1) + qsize(2) + qsize(3);
            if (pending != 0) @(negedge clk);
        end
        checks++;
        if (pending != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", pending);
            clear_queues();
        end
    endtask

    task automatic chk_reset_state(input int k);
        chk("rst_result", k, 32'(res_w[k]), 32'h0);
        chk("rst_flags", k, 32'({busy_w[k], done_w[k], carry_w[k], ovf_w[k], zero_w[k], neg_w[k]}), 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (done_w[k]) begin
                    if (qsize(k) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done unit%0d got=1 expected=0 result=0x%0h", k, res_w[k]);
                    end else begin
                        pop_exp(k, e);
                        $display("unit%0d done cyc=%0d result=0x%02h c=%0b v=%0b z=%0b n=%0b",
                                 k, cyc_cnt, res_w[k], carry_w[k], ovf_w[k], zero_w[k], neg_w[k]);
                        chk("result", k, 32'(res_w[k]), 32'(e.result));
                        chk("carry", k, 32'(carry_w[k]), 32'(e.carry));
                        chk("overflow", k, 32'(ovf_w[k]), 32'(e.overflow));
                        chk("zero", k, 32'(zero_w[k]), 32'(e.zero));
                        chk("negative", k, 32'(neg_w[k]), 32'(e.negative));
                        chk("latency_cycle", k, 32'(cyc_cnt), e.cyc);
                        chk("busy_at_done", k, 32'(busy_w[k]), 32'h0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        set_vec(0, 8'h42, 8'hC0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        set_vec(1, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        set_vec(2, 8'h91, 8'h64, 1'b0, 8'hF5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF5, 1'b0, 1'b1);
        set_vec(3, 8'h32, 8'h9C, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0);
        set_vec(4, 8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        set_vec(5, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0);
        set_vec(6, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        set_vec(7, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        set_vec(8, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset, release with start low, then confirm cleared outputs.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk_reset_state(k);

        // Directed vectors through every variant.
        for (int i = 0; i < 9; i++) begin
            issue(4'hF, i);
            wait_drain();
            repeat (2) @(negedge clk);
        end

        // Back-to-back: start toggles during RUN are ignored, then start in the DONE cycle.
        c0 = cyc_cnt;
        issue(4'hF, 0);
        @(negedge clk);
        a_drv = 8'hFF; b_drv = 8'hFF; sub_drv = 1'b0; en_drv = 4'b0011; start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0; a_drv = 8'h11;
        @(negedge clk);
        start_drv = 1'b1; sub_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        while (cyc_cnt < c0 + 9) @(negedge clk);
        issue(4'hF, 4);
        wait_drain();
        repeat (2) @(negedge clk);

        // Reset at count 4 aborts the operation without a done.
        issue(4'b0011, 3);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        clear_queues();
        #1;
        chk_reset_state(0);
        chk_reset_state(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(4'hF, 0);
        wait_drain();

        // Outputs hold through IDLE.
        repeat (5) @(negedge clk);
        chk("hold_result", 0, 32'(res_w[0]), 32'h02);
        chk("hold_carry", 0, 32'(carry_w[0]), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor with a start/done handshake.
- Successor to the combinational N-bit adder-subtractor. It trades latency for area by processing DIGIT bits per clock.
- Adds a runtime add/sub mode, optional saturation and registered status flags.
- Sits in the datapath as a multi-cycle ALU unit driven by a controller.

Parameters:
- N, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per clock; STEPS = N/DIGIT.
- SATURATE, 0, 1 = clamp signed overflow to the max/min representable value; 0 = wrap.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when ready for a new operation (IDLE or DONE state).
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  N  operand A; sampled with start.
- b  in  N  operand B; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result/flags are updated.
- result  out  N  registered result; held until the next done.
- carry  out  1  carry out of the MSB (in sub mode, 1 = no unsigned borrow, i.e. a >= b).
- overflow  out  1  signed overflow of the unsaturated sum.
- zero  out  1  final result == 0.
- negative  out  1  final result MSB.

Behaviour:
- Reset: clk and a single asynchronous active-low reset rst_n (polarity and synchronicity fixed).
  - rst_n low asynchronously clears state to IDLE, busy = 0, done = 0, result = 0 and all flags to 0.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, on an edge with start = 1:
  - Latch a into opA.
  - Latch (sub ? ~b : b) into opB.
  - Set carry-in to sub and the digit counter to 0.
  - Go to RUN; busy = 1 from this edge.
- RUN, each edge:
  - Add the low DIGIT bits of opA, opB and the carry register.
  - Shift the DIGIT-bit sum into the MSB end of an internal accumulator.
  - Shift opA and opB right by DIGIT.
  - Store the carry; increment the counter.
  - Capture the carry into the final digit's MSB for overflow: overflow = c_in(MSB) XOR c_out(MSB).
- Final step: on the edge processing digit STEPS-1:
  - Write result, carry, overflow, zero and negative.
  - busy = 0 and done = 1; go to DONE.
  - Latency from the start-sampling edge to the done-asserting edge is exactly STEPS edges.
- DONE lasts one cycle.
  - start = 1 in this cycle is accepted, with the same actions as in IDLE; this allows back-to-back operations without an idle gap.
  - Otherwise go to IDLE.
- start while in RUN is ignored, and a, b and sub changes are ignored; operands are internal copies.
- Saturation, when SATURATE = 1 and overflow = 1:
  - result = 0 followed by N-1 ones if the operand-A sign bit is 0.
  - result = 1 followed by N-1 zeros if it is 1.
  - overflow still reports 1; carry is unaffected.
- zero and negative always reflect the final (post-saturation) result.
- Wrap-around with SATURATE = 0: result = (a ± b) mod 2^N.
- DIGIT = N is legal: STEPS = 1, single-cycle latency, still handshaken.
- Outputs hold their values between done pulses, including through IDLE.

Test Plan (N=8, DIGIT=1, SATURATE=0 unless stated):
- Reset check: reset asserted, then released with start = 0 → result = 0x00, all flags 0, busy = 0, done = 0.
- Unsigned wrap and latency: a = 0x42, b = 0xC0, sub = 0, start → done exactly 8 edges later; result = 0x02, carry = 1, overflow = 0, zero = 0.
- Signed add without overflow: a = 0x00, b = 0xFF → 0xFF, negative = 1, carry = 0.
- Signed add without overflow: a = 145, b = 100 → 0xF5, overflow = 0.
- Subtract with borrow and overflow: a = 0x32, b = 0x9C, sub = 1 → result = 0x96, carry = 0, overflow = 1, negative = 1.
  - Same operands with SATURATE = 1 → result = 0x7F, overflow = 1, negative = 0.
- Back-to-back handshake: assert start in the done cycle with a = 0x01, b = 0x01, sub = 1 → second done 8 edges later with result = 0x00, zero = 1, carry = 1.
  - Also toggle start during RUN → no effect.
- Reset mid-operation: pulse rst_n low at count 4 → no done; outputs 0; next start completes normally.
- DIGIT = 4, DIGIT = 8: repeat the unsigned wrap case → latency 2 edges and 1 edge respectively, same result and flags.
